debug_dump_unit: RTL

- Responder for the core's `debug` request line: on a debug pulse it walks the register file, then a window of data memory, and streams every word out over a valid/ready port.
- Sits inside RISCVTop beside the pipeline. It taps a spare register-file read port and a spare data-memory read port, and feeds a trace sink or file writer.
- Gives verification a deterministic architectural-state dump at end of test, replacing hierarchical peeks.

---
 rtl/debug_dump_unit_pkg.sv | 26 ++
 rtl/debug_dump_unit_slot.sv | 29 ++
 rtl/debug_dump_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/debug_dump_unit_pkg.sv
// Shared types for the debug dump responder: FSM states, beat payload and tag values.
package debug_dump_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned RIDX_W = 5;

    localparam logic DUMP_TAG_REG = 1'b0;
    localparam logic DUMP_TAG_MEM = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        REG,
        MEM_REQ,
        MEM_RESP,
        FLUSH,
        DONE
    } dump_state_e;

    typedef struct packed {
        logic              is_mem;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } dump_beat_t;

endpackage

// File: rtl/debug_dump_unit_slot.sv
// Single-entry valid/ready output register; free_c is high when empty or being drained this cycle.
module dump_out_slot
    import debug_dump_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  dump_beat_t beat_in,
    input  logic       ready,
    output logic       valid,
    output dump_beat_t beat,
    output logic       free_c
);

    assign free_c = !valid || ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            beat  <= '0;
        end else if (load && free_c) begin
            valid <= 1'b1;
            beat  <= beat_in;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/debug_dump_unit.sv
// On a debug rising edge, streams every register-file entry and then a window of data memory
// out over a valid/ready port, ascending order, registers first.
module debug_dump_unit
    import debug_dump_unit_pkg::*;
#(
    parameter int unsigned       NUM_REGS  = 32,
    parameter int unsigned       MEM_WORDS = 64,
    parameter logic [ADDR_W-1:0] MEM_BASE  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              debug,
    output logic [RIDX_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic              dump_is_mem,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned MIDX_W = $clog2(MEM_WORDS) + 1;

    dump_state_e       state, state_n;
    logic [RIDX_W-1:0] idx_n;
    logic [MIDX_W-1:0] midx, midx_n;
    logic [ADDR_W-1:0] mem_raddr_n;
    logic              busy_n, done_n, debug_q;
    logic              load_c, slot_free_c;
    dump_beat_t        beat_in_c, slot_beat;

    dump_out_slot u_slot (
        .clk     (clk),
        .rst     (rst),
        .load    (load_c),
        .beat_in (beat_in_c),
        .ready   (dump_ready),
        .valid   (dump_valid),
        .beat    (slot_beat),
        .free_c  (slot_free_c)
    );

    assign dump_is_mem = slot_beat.is_mem;
    assign dump_addr   = slot_beat.addr;
    assign dump_data   = slot_beat.data;

    // rf_raddr doubles as the register index; mem_raddr is held across each request/response pair
    always_comb begin
        state_n     = state;
        idx_n       = rf_raddr;
        midx_n      = midx;
        mem_raddr_n = MEM_BASE;
        load_c      = 1'b0;
        beat_in_c   = '0;
        unique case (state)
            IDLE: begin
                idx_n  = '0;
                midx_n = '0;
                if (debug && !debug_q) state_n = REG;
            end
            REG: begin
                beat_in_c.is_mem = DUMP_TAG_REG;
                beat_in_c.addr   = ADDR_W'(rf_raddr);
                beat_in_c.data   = rf_rdata;
                if (slot_free_c) begin
                    load_c = 1'b1;
                    if (rf_raddr == RIDX_W'(NUM_REGS - 1)) begin
                        idx_n   = '0;
                        state_n = MEM_REQ;
                    end else begin
                        idx_n = rf_raddr + RIDX_W'(1);
                    end
                end
            end
            MEM_REQ: begin
                mem_raddr_n = mem_raddr;
                state_n     = MEM_RESP;
            end
            MEM_RESP: begin
                mem_raddr_n      = mem_raddr;
                beat_in_c.is_mem = DUMP_TAG_MEM;
                beat_in_c.addr   = mem_raddr;
                beat_in_c.data   = mem_rdata;
                if (slot_free_c) begin
                    load_c = 1'b1;
                    if (midx == MIDX_W'(MEM_WORDS - 1)) begin
                        mem_raddr_n = MEM_BASE;
                        state_n     = FLUSH;
                    end else begin
                        midx_n      = midx + MIDX_W'(1);
                        mem_raddr_n = mem_raddr + ADDR_W'(4);
                        state_n     = MEM_REQ;
                    end
                end
            end
            FLUSH: begin
                if (dump_valid && dump_ready) state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = state_n inside {REG, MEM_REQ, MEM_RESP, FLUSH};
        done_n = (state_n == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rf_raddr  <= '0;
            midx      <= '0;
            mem_raddr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            debug_q   <= 1'b0;
        end else begin
            state     <= state_n;
            rf_raddr  <= idx_n;
            midx      <= midx_n;
            mem_raddr <= mem_raddr_n;
            busy      <= busy_n;
            done      <= done_n;
            debug_q   <= debug;
        end
    end

endmodule
